pcie_class_arbiter: RTL and testbench

Downstream neighbour of the class dispatcher (device1). Device1 splits the 10-bit input stream by class bit [9] into FIFO0 (class 0) and FIFO1 (class 1). This block drains both FIFOs with weighted round-robin and merges them onto one output stream toward the egress FIFO. It honours egress backpressure (pause), checks class tags, and keeps per-class word counters.

---
 rtl/pcie_pkg.sv | 15 +
 rtl/pcie_class_arbiter_sat_counter.sv | 19 +
 rtl/pcie_class_arbiter.sv | 153 +++++++++++++++
 tb/tb_pcie_class_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_pkg.sv
// rtl/pcie_pkg.sv - shared state encoding and class constants for the class arbiter
package pcie_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE1 = 2'd1,
        SERVE0 = 2'd2
    } arb_state_t;

    localparam logic CLASS0 = 1'b0;
    localparam logic CLASS1 = 1'b1;

    localparam int DEFAULT_DATA_SIZE = 10;

endpackage

// File: rtl/pcie_class_arbiter_sat_counter.sv
// rtl/pcie_class_arbiter_sat_counter.sv - saturating up-counter for per-class word counts
module sat_counter #(
    parameter int CNT_SIZE = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    output logic [CNT_SIZE-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_SIZE{1'b1}})) begin
            count <= count + CNT_SIZE'(1);
        end
    end

endmodule

// File: rtl/pcie_class_arbiter.sv
// rtl/pcie_class_arbiter.sv - weighted round-robin merge of the two class FIFOs onto one stream
module pcie_class_arbiter
    import pcie_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int WEIGHT1   = 3,
    parameter int WEIGHT0   = 1,
    parameter int CNT_SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] fifo0_data,
    input  logic                 fifo0_empty,
    input  logic [DATA_SIZE-1:0] fifo1_data,
    input  logic                 fifo1_empty,
    input  logic                 pause,
    output logic                 pop0,
    output logic                 pop1,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 tag_error,
    output logic [CNT_SIZE-1:0]  cnt0,
    output logic [CNT_SIZE-1:0]  cnt1
);

    localparam logic [3:0] W1 = 4'(WEIGHT1);
    localparam logic [3:0] W0 = 4'(WEIGHT0);

    arb_state_t state_q, state_d;
    logic [3:0] burst_q, burst_d;
    logic       pop0_d, pop1_d;
    logic [1:0] src_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            burst_q <= '0;
            pop0    <= 1'b0;
            pop1    <= 1'b0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            pop0    <= pop0_d;
            pop1    <= pop1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        pop0_d  = 1'b0;
        pop1_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pause) begin
                    burst_d = '0;
                end else if (!fifo1_empty) begin
                    state_d = SERVE1;
                    burst_d = 4'd1;
                    pop1_d  = 1'b1;
                end else if (!fifo0_empty) begin
                    state_d = SERVE0;
                    burst_d = 4'd1;
                    pop0_d  = 1'b1;
                end else begin
                    burst_d = '0;
                end
            end
            SERVE1: begin
                if (pause) begin
                    state_d = SERVE1;
                end else if (!fifo1_empty && (burst_q < W1)) begin
                    pop1_d  = 1'b1;
                    burst_d = burst_q + 4'd1;
                end else if (!fifo0_empty) begin
                    state_d = SERVE0;
                    burst_d = 4'd1;
                    pop0_d  = 1'b1;
                end else if (!fifo1_empty) begin
                    burst_d = 4'd1;
                    pop1_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    burst_d = '0;
                end
            end
            SERVE0: begin
                if (pause) begin
                    state_d = SERVE0;
                end else if (!fifo0_empty && (burst_q < W0)) begin
                    pop0_d  = 1'b1;
                    burst_d = burst_q + 4'd1;
                end else if (!fifo1_empty) begin
                    state_d = SERVE1;
                    burst_d = 4'd1;
                    pop1_d  = 1'b1;
                end else if (!fifo0_empty) begin
                    burst_d = 4'd1;
                    pop0_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                burst_d = '0;
            end
        endcase
    end

    // src_q marks which FIFO presents read data this cycle (pop delayed by one)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            tag_error <= 1'b0;
        end else begin
            src_q <= {pop1, pop0};
            if (src_q[1]) begin
                data_out  <= fifo1_data;
                valid_out <= 1'b1;
                if (fifo1_data[DATA_SIZE-1] != CLASS1) begin
                    tag_error <= 1'b1;
                end
            end else if (src_q[0]) begin
                data_out  <= fifo0_data;
                valid_out <= 1'b1;
                if (fifo0_data[DATA_SIZE-1] != CLASS0) begin
                    tag_error <= 1'b1;
                end
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

    sat_counter #(.CNT_SIZE(CNT_SIZE)) u_cnt0 (
        .clk   (clk),
        .reset (reset),
        .inc   (src_q[0]),
        .count (cnt0)
    );

    sat_counter #(.CNT_SIZE(CNT_SIZE)) u_cnt1 (
        .clk   (clk),
        .reset (reset),
        .inc   (src_q[1]),
        .count (cnt1)
    );

endmodule

// File: tb/tb_pcie_class_arbiter.sv
// tb/tb_pcie_class_arbiter.sv - directed self-checking bench for pcie_class_arbiter
module tb_pcie_class_arbiter;

    localparam int DW = 10;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] fifo0_data = '0;
    logic [DW-1:0] fifo1_data = '0;
    logic          fifo0_empty, fifo1_empty;
    logic          pause;
    logic          pop0, pop1;
    logic [DW-1:0] data_out;
    logic          valid_out, tag_error;
    logic [CW-1:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcie_class_arbiter #(
        .DATA_SIZE (DW),
        .WEIGHT1   (3),
        .WEIGHT0   (1),
        .CNT_SIZE  (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo0_data  (fifo0_data),
        .fifo0_empty (fifo0_empty),
        .fifo1_data  (fifo1_data),
        .fifo1_empty (fifo1_empty),
        .pause       (pause),
        .pop0        (pop0),
        .pop1        (pop1),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .tag_error   (tag_error),
        .cnt0        (cnt0),
        .cnt1        (cnt1)
    );

    // FIFO model: empty already accounts for a pop being presented this cycle
    logic [DW-1:0] mem0 [0:1023];
    logic [DW-1:0] mem1 [0:1023];
    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
    int underflow = 0;
    int both_pop  = 0;

    assign fifo0_empty = ((wr0 - rd0 - (pop0 ? 1 : 0)) <= 0);
    assign fifo1_empty = ((wr1 - rd1 - (pop1 ? 1 : 0)) <= 0);

    always @(posedge clk) begin
        if (pop0) begin
            if (wr0 == rd0) underflow <= underflow + 1;
            fifo0_data <= mem0[rd0 % 1024];
            rd0        <= rd0 + 1;
        end
        if (pop1) begin
            if (wr1 == rd1) underflow <= underflow + 1;
            fifo1_data <= mem1[rd1 % 1024];
            rd1        <= rd1 + 1;
        end
    end

    int            pop_log [$];
    logic [DW-1:0] out_log [$];
    bit            rec = 1'b0;

    always @(negedge clk) begin
        if (pop0 && pop1) both_pop <= both_pop + 1;
        if (rec) begin
            if (pop1) pop_log.push_back(1);
            if (pop0) pop_log.push_back(0);
            if (valid_out) out_log.push_back(data_out);
        end
    end

    int            exp_pops [10] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0};
    logic [DW-1:0] exp_data [10] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h155, 10'h3FF,
                                     10'h3FF, 10'h155, 10'h155, 10'h155, 10'h155};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put0(input logic [DW-1:0] v);
        mem0[wr0 % 1024] = v;
        wr0++;
    endtask

    task automatic put1(input logic [DW-1:0] v);
        mem1[wr1 % 1024] = v;
        wr1++;
    endtask

    task automatic load_both();
        for (int i = 0; i < 5; i++) begin
            put1(10'h3FF);
            put0(10'h155);
        end
    endtask

    task automatic drain(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 2000) begin
            @(negedge clk);
            n++;
            if (fifo0_empty && fifo1_empty && !pop0 && !pop1 && !valid_out) quiet++;
            else quiet = 0;
        end
        chk({tag, "_drain_timeout"}, (quiet >= 4), 1);
    endtask

    task automatic start_log();
        @(posedge clk);
        #1;
        pop_log.delete();
        out_log.delete();
        rec = 1'b1;
    endtask

    task automatic check_logs(input string tag);
        chk({tag, "_pop_count"}, pop_log.size(), 10);
        chk({tag, "_out_count"}, out_log.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < pop_log.size()) chk($sformatf("%s_pop%0d", tag, i), pop_log[i], exp_pops[i]);
            if (i < out_log.size()) chk($sformatf("%s_out%0d", tag, i), out_log[i], exp_data[i]);
        end
    endtask

    initial begin
        int n1;
        int k;
        int vcount;

        pause = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {pop0, pop1, valid_out, data_out, tag_error, cnt0, cnt1}, 0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d", i), {pop0, pop1, valid_out, cnt0, cnt1}, 0);
        end

        // weighted round-robin, no pause
        start_log();
        load_both();
        drain("base");
        rec = 1'b0;
        check_logs("base");
        chk("base_cnt1", cnt1, 5);
        chk("base_cnt0", cnt0, 5);
        chk("base_tag", tag_error, 0);

        // pause after the second class-1 pop
        start_log();
        load_both();
        n1 = 0;
        k = 0;
        while (n1 < 2 && k < 100) begin
            @(negedge clk);
            k++;
            if (pop1) n1++;
        end
        chk("pause_reach", n1, 2);
        pause  = 1'b1;
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("pause_nopop%0d", i), (pop0 | pop1), 0);
            if (valid_out) vcount++;
        end
        pause = 1'b0;
        chk("pause_trailing_words", vcount, 2);
        drain("pause");
        rec = 1'b0;
        check_logs("pause");
        chk("pause_cnt1", cnt1, 10);
        chk("pause_cnt0", cnt0, 10);

        // class tag mismatch on FIFO0
        @(posedge clk);
        #1;
        put0(10'h2AA);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!valid_out && k < 50);
        chk("tag_valid_seen", valid_out, 1);
        chk("tag_data", data_out, 10'h2AA);
        chk("tag_err_rise", tag_error, 1);
        drain("tag");
        chk("tag_err_sticky", tag_error, 1);
        chk("tag_cnt0", cnt0, 11);
        chk("tag_cnt1", cnt1, 10);

        // reset mid-burst after two pops
        @(posedge clk);
        #1;
        load_both();
        n1 = 0;
        k = 0;
        while (n1 < 2 && k < 100) begin
            @(negedge clk);
            k++;
            if (pop1 || pop0) n1++;
        end
        reset = 1'b0;
        #1;
        chk("midrst_outputs", {pop0, pop1, valid_out, data_out, tag_error, cnt0, cnt1}, 0);
        @(negedge clk);
        reset = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(pop0 || pop1) && k < 50);
        chk("midrst_first_pop", {pop1, pop0}, 2'b10);
        drain("midrst");
        chk("midrst_tag", tag_error, 0);

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // counter saturation
        @(posedge clk);
        #1;
        for (int i = 0; i < 300; i++) put0(10'h055);
        drain("sat");
        chk("sat_cnt0", cnt0, 255);
        chk("sat_cnt1", cnt1, 0);
        chk("sat_tag", tag_error, 0);

        chk("no_underflow", underflow, 0);
        chk("no_double_pop", both_pop, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
